instr_fifo_drain: RTL and testbench

//  Read-side consumer for the instruction FIFO. Issues pops on the FIFO read port (rr/empty/dout) and absorbs
//  its 1-cycle read latency in a 2-entry skid buffer. Re-presents words downstream on a valid/ready handshake
//  at up to 1 word/cycle. Sits between the instruction FIFO and the decode stage; flush discards queued
//  and in-flight words.

---
 rtl/instr_fifo_drain.sv | 147 ++++++++++++++
 tb/tb_instr_fifo_drain.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fifo_drain.sv
// Instruction FIFO read-side drain: pops the FIFO, absorbs read latency in a skid buffer.
// Optional INSTR_DRAIN_STATS_EN adds saturating pop/stall counters.
module instr_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fifo_empty,
  output logic                                 fifo_rr,
  input  logic [DATA_WIDTH-1:0]                fifo_dout,
  input  logic                                 flush,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [$clog2(SKID_DEPTH+1)-1:0]      occ
`ifdef INSTR_DRAIN_STATS_EN
  ,
  output logic [15:0]                          stat_pops,
  output logic [15:0]                          stat_stalls
`endif
);

  localparam int OW = $clog2(SKID_DEPTH+1);
  localparam int PW = $clog2(SKID_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  inflight;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  pop;
  logic                  cap;
  logic [OW:0]           need;
  logic [OW-1:0]         occ_nxt;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;
  // A word arriving while in FLUSH belongs to a pre-flush read.
  assign cap       = inflight & (state != FLUSH);
  assign need      = {1'b0, occ} + {{OW{1'b0}}, inflight}
                   - {{OW{1'b0}}, pop};

  always_comb begin
    occ_nxt = occ;
    if (cap && !pop)
      occ_nxt = occ + OW'(1);
    else if (!cap && pop)
      occ_nxt = occ - OW'(1);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (flush)
          state_nxt = FLUSH;
        else if (fifo_rr)
          state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (flush)
          state_nxt = FLUSH;
        else if (occ_nxt == '0 && !fifo_rr)
          state_nxt = IDLE;
      end
      FLUSH: begin
        state_nxt = flush ? FLUSH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fifo_rr  = 1'b0;
    out_data = '0;
    if (!rst && !fifo_empty && !flush && state != FLUSH
        && need < (OW+1)'(SKID_DEPTH))
      fifo_rr = 1'b1;
    if (out_valid)
      out_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= fifo_rr;
      if (flush) begin
        occ    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        occ <= occ_nxt;
        if (cap)
          wr_ptr <= bump(wr_ptr);
        if (pop)
          rd_ptr <= bump(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && cap)
      mem[wr_ptr] <= fifo_dout;
  end

`ifdef INSTR_DRAIN_STATS_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pops   <= '0;
      stat_stalls <= '0;
    end else begin
      if (pop && stat_pops != 16'hFFFF)
        stat_pops <= stat_pops + 16'd1;
      if (out_valid && !out_ready && stat_stalls != 16'hFFFF)
        stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fifo_drain.sv
// Scoreboard bench for instr_fifo_drain: FIFO model, expected-word queue, directed + random.
// Stats checks compile in when INSTR_DRAIN_STATS_EN is defined.
module tb_instr_fifo_drain;
  localparam int DW = 8;
  localparam int SD = 2;
  localparam int OW = $clog2(SD+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rr;
  logic [DW-1:0] fifo_dout;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [OW-1:0] occ;
`ifdef INSTR_DRAIN_STATS_EN
  logic [15:0]   stat_pops;
  logic [15:0]   stat_stalls;
`endif

  instr_fifo_drain #(.DATA_WIDTH(DW), .SKID_DEPTH(SD)) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_rr(fifo_rr), .fifo_dout(fifo_dout),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occ(occ)
`ifdef INSTR_DRAIN_STATS_EN
    , .stat_pops(stat_pops), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic hold = 1'b0;
  logic rr_s = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic refresh();
    fifo_empty = hold || (fq.size() == 0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  // FIFO model: 1-cycle read latency; junk on dout when not reading.
  always @(posedge clk) begin
    #1;
    if (rr_s && fq.size() != 0)
      fifo_dout = fq.pop_front();
    else
      fifo_dout = DW'($urandom);
    refresh();
  end

  // Every committed read yields a word expected downstream, in order.
  always @(negedge clk) begin
    rr_s = fifo_rr;
    if (fifo_rr) begin
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL rr_on_empty got=1 want=0");
      end else
        exp_q.push_back(fq[0]);
    end
  end

  // Monitor: compare on handshake; flush drops everything not consumed.
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      chk("occ_bound", 32'(occ <= OW'(SD)), 1);
      chk("valid_occ", out_valid, occ != '0);
      if (prev_hold)
        chk("data_held", {out_valid, out_data}, {1'b1, prev_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra got=%0h want=none", out_data);
        end else
          chk("sb_data", out_data, exp_q.pop_front());
      end
      if (flush)
        exp_q.delete();
      prev_hold = out_valid && !out_ready && !flush;
      prev_data = out_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  int rrc;
  int vc;
  int first;
  int omax;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    fifo_dout = '0; fifo_empty = 1'b1;
    for (int i = 0; i < 8; i++) fq.push_back(DW'(8'h11 + i));
    refresh();

    // Reset holds everything quiet despite a non-empty FIFO.
    for (int i = 0; i < 3; i++) begin
      obs();
      chk("rst_rr", fifo_rr, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_occ", occ, 0);
      adv();
    end
    rst = 1'b0;
    out_ready = 1'b1;

    // Streaming at one word per cycle.
    omax = 0;
    for (int k = 0; k < 14; k++) begin
      obs();
      chk("stream_rr", fifo_rr, k < 8);
      chk("stream_valid", out_valid, k >= 2 && k < 10);
      if (k >= 2 && k < 10)
        chk("stream_data", out_data, 8'h11 + k - 2);
      if (int'(occ) > omax) omax = int'(occ);
      adv();
    end
    chk("stream_occmax", 32'(omax <= 2), 1);

    // Backpressure: two reads fill the buffer, head held.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(DW'(8'h11 + i));
    refresh();
    rrc = 0;
    for (int k = 0; k < 6; k++) begin
      obs();
      rrc += int'(fifo_rr);
      adv();
    end
    obs();
    chk("bp_rr_count", rrc, 2);
    chk("bp_occ", occ, 2);
    chk("bp_data", {out_valid, out_data}, {1'b1, 8'h11});
    adv();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      obs();
      chk("bp_drain", {out_valid, out_data}, {1'b1, 8'(8'h11 + k)});
      adv();
    end
    for (int k = 0; k < 4; k++) adv();

    // Flush with a word buffered and one in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(DW'(8'h21 + i));
    refresh();
    obs(); chk("fl_rr0", fifo_rr, 1); adv();
    obs(); chk("fl_rr1", fifo_rr, 1); adv();
    flush = 1'b1;
    obs(); chk("fl_occ_pre", occ, 1); chk("fl_rr_gate", fifo_rr, 0);
    adv();
    flush = 1'b0;
    obs();
    chk("fl_after", {out_valid, occ, fifo_rr}, {1'b0, OW'(0), 1'b0});
    adv();
    obs(); chk("fl_resume", fifo_rr, 1); adv();
    out_ready = 1'b1;
    vc = 0;
    for (int k = 0; k < 10 && vc == 0; k++) begin
      obs();
      if (out_valid) begin
        vc = 1;
        chk("fl_first_word", out_data, 8'h23);
      end
      adv();
    end
    chk("fl_word_seen", vc, 1);
    for (int k = 0; k < 6; k++) adv();

    // Single word then FIFO empty.
    fq.push_back(8'hA5);
    refresh();
    rrc = 0; vc = 0;
    for (int k = 0; k < 8; k++) begin
      obs();
      rrc += int'(fifo_rr);
      if (out_valid) begin
        vc++;
        chk("one_data", out_data, 8'hA5);
      end
      adv();
    end
    obs();
    chk("one_rr", rrc, 1);
    chk("one_valid", vc, 1);
    chk("one_idle", {out_valid, occ, fifo_rr}, {1'b0, OW'(0), 1'b0});
    adv();

`ifdef INSTR_DRAIN_STATS_EN
    rst = 1'b1; adv(); rst = 1'b0;
    obs(); chk("st_rst", {stat_pops, stat_stalls}, 0); adv();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(DW'(8'h31 + i));
    refresh();
    for (int k = 0; k < 20; k++) begin
      obs();
      if (out_valid) break;
      adv();
    end
    adv(); adv(); adv();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) adv();
    obs();
    chk("st_pops", stat_pops, 4);
    chk("st_stalls", stat_stalls, 3);
    adv();
    flush = 1'b1; adv(); flush = 1'b0;
    obs(); chk("st_flush", {stat_pops, stat_stalls}, {16'd4, 16'd3}); adv();
    rst = 1'b1; adv(); rst = 1'b0;
    obs(); chk("st_rst2", {stat_pops, stat_stalls}, 0); adv();
`endif

    // Random traffic against the scoreboard.
    for (int k = 0; k < 3000; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 24) == 0);
      if (fq.size() < 3 && $urandom_range(0, 1) == 1)
        fq.push_back(DW'($urandom));
      refresh();
      adv();
    end
    flush = 1'b0; hold = 1'b0; out_ready = 1'b1;
    refresh();
    for (int k = 0; k < 20; k++) adv();
    obs();
    chk("rand_sb_empty", exp_q.size(), 0);
    chk("rand_idle", {out_valid, occ}, 0);
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
